// File: rtl/sdram_pattern_tester.sv
// Purpose: SDRAM self-test traffic generator; writes a 2^COUNT_WIDTH-word pattern block, reads it back, counts mismatches.
// Latency: button low to first wr_enable is 4 cycles; 3 cycles per written word, 5 per read word with immediate rd_rdy.
// Backpressure: each request waits for busy low; one outstanding read, abandoned after 2^TIMEOUT_WIDTH cycles with no rd_rdy.
// Ports: clk, rst_n (async, active-low); button_n (async start button), dip {read-only, loop, mode[1:0]};
//        host side haddr, wr_data, wr_enable, rd_enable, rd_ack out and busy, rd_data, rd_rdy in;
//        status done, err_cnt, fail_addr and leds {pass, fail, running, err_cnt clipped to 31}.
module sdram_pattern_tester #(
  parameter int                      HADDR_WIDTH   = 24,
  parameter int                      DATA_WIDTH    = 16,
  parameter int                      COUNT_WIDTH   = 8,
  parameter logic [HADDR_WIDTH-1:0]  BASE_ADDR     = '0,
  parameter logic [DATA_WIDTH-1:0]   SEED          = DATA_WIDTH'(16'hA5C3),
  parameter int                      ERR_WIDTH     = 8,
  parameter int                      TIMEOUT_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   button_n,
  input  logic [3:0]             dip,
  output logic [7:0]             leds,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_enable,
  output logic                   rd_enable,
  input  logic                   busy,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_rdy,
  output logic                   rd_ack,
  output logic                   done,
  output logic [ERR_WIDTH-1:0]   err_cnt,
  output logic [HADDR_WIDTH-1:0] fail_addr
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_REQ   = 4'd1;
  localparam logic [3:0] S_WR_ISSUE = 4'd2;
  localparam logic [3:0] S_WR_GAP   = 4'd3;
  localparam logic [3:0] S_RD_REQ   = 4'd4;
  localparam logic [3:0] S_RD_ISSUE = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_RD_ACK   = 4'd7;
  localparam logic [3:0] S_RD_NEXT  = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [COUNT_WIDTH-1:0]   IDX_MAX = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX  = '1;
  localparam logic [ERR_WIDTH-1:0]     ERR_MAX = '1;

  logic [3:0]             state_q, state_d;
  logic [3:0]             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0]  rdat_q, rdat_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic [HADDR_WIDTH-1:0] fail_q, fail_d;
  logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   sync1_q, sync2_q, prev_q;

  logic                   start;
  logic                   ld_addr;
  logic                   rec_err;
  logic [HADDR_WIDTH-1:0] addr_nxt;

  // Write data doubles as the expected read word, so both phases share one generator.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [HADDR_WIDTH-1:0] a,
                                                    input logic [1:0]             m);
    logic [DATA_WIDTH-1:0] lo;
    lo = DATA_WIDTH'(a);
    case (m)
      2'b00:   pattern = SEED;
      2'b01:   pattern = lo;
      2'b10:   pattern = ~lo;
      default: pattern = a[0] ? ~SEED : SEED;
    endcase
  endfunction

  // Synchronisers idle high (button released) so reset never produces a start pulse.
  assign start = prev_q & ~sync2_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    fail_d  = fail_q;
    ld_addr = 1'b0;
    rec_err = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = dip;
          err_d   = '0;
          fail_d  = '0;
          idx_d   = '0;
          ld_addr = 1'b1;
          state_d = dip[3] ? S_RD_REQ : S_WR_REQ;
        end else if ((state_q == S_DONE) && mode_q[2]) begin
          // Loop restart keeps the accumulated error record.
          idx_d   = '0;
          ld_addr = 1'b1;
          state_d = mode_q[3] ? S_RD_REQ : S_WR_REQ;
        end
      end
      S_WR_REQ:   if (!busy) state_d = S_WR_ISSUE;
      S_WR_ISSUE: state_d = S_WR_GAP;
      S_WR_GAP: begin
        ld_addr = 1'b1;
        if (idx_q == IDX_MAX) begin
          idx_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          idx_d   = idx_q + COUNT_WIDTH'(1);
          state_d = S_WR_REQ;
        end
      end
      S_RD_REQ:   if (!busy) state_d = S_RD_ISSUE;
      S_RD_ISSUE: begin
        wd_d    = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // rd_rdy wins over the watchdog in the terminal cycle.
        if (rd_rdy) begin
          rdat_d  = rd_data;
          state_d = S_RD_ACK;
        end else if (wd_q == WD_MAX) begin
          rec_err = 1'b1;
          state_d = S_RD_NEXT;
        end else begin
          wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
      end
      S_RD_ACK: begin
        rec_err = (rdat_q != wr_data_q);
        state_d = S_RD_NEXT;
      end
      S_RD_NEXT: begin
        // Guard cycle: a late or lingering rd_rdy is deliberately not looked at here.
        if (idx_q == IDX_MAX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + COUNT_WIDTH'(1);
          ld_addr = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rec_err) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_WIDTH'(1);
      if (err_q == '0)      fail_d = haddr_q;
    end

    // Address and pattern only move when the index is (re)loaded, so they stay stable
    // for the whole request/response of one word and read zero until the first start.
    addr_nxt  = BASE_ADDR + HADDR_WIDTH'(idx_d);
    haddr_d   = ld_addr ? addr_nxt : haddr_q;
    wr_data_d = ld_addr ? pattern(addr_nxt, mode_d[1:0]) : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      idx_q     <= '0;
      wd_q      <= '0;
      rdat_q    <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      haddr_q   <= '0;
      wr_data_q <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      haddr_q   <= haddr_d;
      wr_data_q <= wr_data_d;
      sync1_q   <= button_n;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  // Outputs are registers or pure decodes of state_q; nothing from the host inputs leaks through.
  assign haddr     = haddr_q;
  assign wr_data   = wr_data_q;
  assign wr_enable = (state_q == S_WR_ISSUE);
  assign rd_enable = (state_q == S_RD_ISSUE);
  assign rd_ack    = (state_q == S_RD_ACK);
  assign done      = (state_q == S_DONE);
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

  assign leds[7]   = done && (err_q == '0);
  assign leds[6]   = (err_q != '0);
  assign leds[5]   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign leds[4:0] = (err_q > ERR_WIDTH'(31)) ? 5'd31 : err_q[4:0];

endmodule

// File: tb/tb_sdram_pattern_tester.sv
module tb_sdram_pattern_tester;

  logic        clk;
  logic        rst_n;
  logic        button_n;
  logic [3:0]  dip;
  logic [7:0]  leds;
  logic [23:0] haddr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic        rd_enable;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_rdy;
  logic        rd_ack;
  logic        done;
  logic [7:0]  err_cnt;
  logic [23:0] fail_addr;

  sdram_pattern_tester #(.TIMEOUT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button_n  (button_n),
    .dip       (dip),
    .leds      (leds),
    .haddr     (haddr),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .rd_enable (rd_enable),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_rdy    (rd_rdy),
    .rd_ack    (rd_ack),
    .done      (done),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Controller model / protocol monitor state
  logic [15:0] mem [256];
  bit          corrupt [256];
  logic [23:0] wr_a[$];
  logic [15:0] wr_d[$];
  logic [23:0] rd_a[$];
  int          viol, acks, gap, lat_cnt;
  int          lat_lo, lat_hi;
  bit          pend, force_busy, rd_never;
  logic [7:0]  paddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input logic c);
    chk(tag, 32'(c), 32'd1);
  endtask

  // Reference pattern written straight from the mode table.
  function automatic logic [15:0] exp_pat(input int a, input logic [1:0] m);
    case (m)
      2'b00:   return 16'hA5C3;
      2'b01:   return a[15:0];
      2'b10:   return ~a[15:0];
      default: return ((a % 2) == 1) ? 16'h5A3C : 16'hA5C3;
    endcase
  endfunction

  function automatic logic [7:0] exp_leds(input int e, input bit dn);
    int s;
    s = (e > 31) ? 31 : e;
    return {dn && (e == 0), e != 0, 1'b0, 5'(s)};
  endfunction

  // Ideal controller: one busy cycle after each strobe, read data from a word array,
  // optional per-address corruption and random read latency; also polices the host protocol.
  initial begin
    busy = 1'b0; rd_rdy = 1'b0; rd_data = '0;
    pend = 1'b0; gap = 3; lat_cnt = 0; paddr = '0;
    foreach (mem[i]) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; rd_rdy = 1'b0; busy = force_busy; gap = 3;
        continue;
      end
      if ((wr_enable || rd_enable) && (busy || gap < 3)) viol++;
      gap = (wr_enable || rd_enable) ? 1 : ((gap < 3) ? gap + 1 : 3);
      if (rd_ack && !rd_rdy) viol++;
      if (rd_ack) begin
        acks++; rd_rdy = 1'b0; pend = 1'b0;
      end
      if (rd_enable && pend && !rd_never) viol++;
      if (wr_enable) begin
        mem[haddr[7:0]] = wr_data;
        wr_a.push_back(haddr);
        wr_d.push_back(wr_data);
      end
      if (rd_enable) begin
        pend = 1'b1; paddr = haddr[7:0];
        lat_cnt = $urandom_range(lat_hi, lat_lo);
        rd_a.push_back(haddr);
      end
      if (rd_never) pend = 1'b0;
      if (pend && !rd_rdy) begin
        if (lat_cnt == 0) begin
          rd_rdy  = 1'b1;
          rd_data = mem[paddr] ^ (corrupt[paddr] ? 16'h0100 : 16'h0000);
        end else begin
          lat_cnt--;
        end
      end
      busy = force_busy || wr_enable || rd_enable;
    end
  end

  task automatic clear_sb();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    viol = 0; acks = 0;
  endtask

  task automatic clear_corrupt();
    foreach (corrupt[i]) corrupt[i] = 1'b0;
  endtask

  task automatic press(output int n);
    button_n = 1'b0;
    n = 0;
    while (!(wr_enable || rd_enable) && n < 20) begin
      @(negedge clk);
      n++;
    end
    button_n = 1'b1;
  endtask

  task automatic press_raw();
    button_n = 1'b0;
    repeat (4) @(negedge clk);
    button_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_true({tag, "_done_in_time"}, n < budget);
  endtask

  task automatic check_run(input string tag, input logic [1:0] m, input bit wrote,
                           input int e, input int fa, input int nack);
    int bad;
    int ecap;
    ecap = (e > 255) ? 255 : e;
    chk({tag, "_wr_cnt"}, 32'(wr_a.size()), wrote ? 32'd256 : 32'd0);
    bad = 0;
    foreach (wr_a[i]) if (wr_a[i] !== 24'(i) || wr_d[i] !== exp_pat(i, m)) bad++;
    chk({tag, "_wr_seq"}, 32'(bad), 32'd0);
    chk({tag, "_rd_cnt"}, 32'(rd_a.size()), 32'd256);
    bad = 0;
    foreach (rd_a[i]) if (rd_a[i] !== 24'(i)) bad++;
    chk({tag, "_rd_seq"}, 32'(bad), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ecap));
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(fa));
    chk({tag, "_leds"}, 32'(leds), 32'(exp_leds(e, 1'b1)));
    chk({tag, "_acks"}, 32'(acks), 32'(nack));
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] d, input int e, input int fa, input int nack);
    int lat;
    clear_sb();
    dip = d;
    press(lat);
    chk_true({tag, "_start_latency"}, lat >= 4 && lat <= 6);
    wait_done(12000, tag);
    check_run(tag, d[1:0], !d[3], e, fa, nack);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_haddr"}, 32'(haddr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_strobes"}, 32'({wr_enable, rd_enable, rd_ack}), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
    chk({tag, "_leds"}, 32'(leds), 32'd0);
  endtask

  initial begin
    int n, s, k, first, m, lat;
    rst_n = 1'b1; button_n = 1'b1; dip = '0;
    force_busy = 1'b0; rd_never = 1'b0; lat_lo = 0; lat_hi = 0;
    viol = 0; acks = 0;
    clear_corrupt();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_leds", 32'(leds), 32'd0);

    // Mode 00, immediate read data
    run("m00", 4'b0000, 0, 0, 256);
    repeat (20) @(negedge clk);
    chk("m00_done_held", 32'(done), 32'd1);
    chk("m00_no_restart", 32'(wr_a.size()), 32'd256);
    chk("m00_leds_80", 32'(leds), 32'h80);

    // Read-only over the block just written
    run("ro", 4'b1000, 0, 0, 256);

    // Mode 01 with address 5 corrupted on read
    lat_hi = 2;
    corrupt[5] = 1'b1;
    run("m01c5", 4'b0001, 1, 5, 256);
    chk("m01c5_leds_41", 32'(leds), 32'h41);
    clear_corrupt();

    // Random pattern modes, corruption sets and read latencies
    lat_hi = 3;
    for (int r = 0; r < 3; r++) begin
      clear_corrupt();
      m = $urandom_range(3, 0);
      k = $urandom_range(3, 0);
      first = 256;
      for (int j = 0; j < k; j++) begin
        int a;
        do a = $urandom_range(255, 0); while (corrupt[a]);
        corrupt[a] = 1'b1;
        if (a < first) first = a;
      end
      run($sformatf("rnd%0d", r), {2'b00, 2'(m)}, k, (k == 0) ? 0 : first, 256);
    end
    clear_corrupt();

    // busy held high for 50 cycles during the write phase
    clear_sb();
    dip = 4'b0010;
    press(lat);
    n = 0;
    while (wr_a.size() < 30 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_true("busy_reach_30_writes", n < 500);
    #1 force_busy = 1'b1;
    repeat (2) @(negedge clk);
    s = wr_a.size();
    repeat (48) @(negedge clk);
    chk("busy_no_write_while_busy", 32'(wr_a.size()), 32'(s));
    #1 force_busy = 1'b0;
    n = 0;
    while (wr_a.size() == s && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_true("busy_resume_delay", n >= 2 && n <= 3);
    wait_done(12000, "busy");
    check_run("busy", 2'b10, 1'b1, 0, 0, 256);

    // rd_rdy never returned: every read times out, counter saturates
    rd_never = 1'b1;
    run("tmo", 4'b1000, 256, 0, 0);
    chk("tmo_leds_5f", 32'(leds), 32'h5F);
    rd_never = 1'b0;

    // Loop mode with two corrupted words
    corrupt[7] = 1'b1;
    corrupt[200] = 1'b1;
    clear_sb();
    dip = 4'b0111;
    press(lat);
    wait_done(12000, "loop1");
    check_run("loop1", 2'b11, 1'b1, 2, 7, 256);
    clear_sb();
    n = 0;
    while (wr_a.size() == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_true("loop_autostart", n >= 1 && n <= 6);
    while (wr_a.size() < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    press_raw();
    dip = 4'b0000;
    wait_done(12000, "loop2");
    check_run("loop2", 2'b11, 1'b1, 4, 7, 256);

    // Asynchronous reset while a read is outstanding
    lat_lo = 10;
    lat_hi = 10;
    n = 0;
    while (rd_enable !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk_true("rst_reach_read", n < 3000);
    repeat (2) @(negedge clk);
    chk("rst_pre_running", 32'(leds[5]), 32'd1);
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat_lo = 0;
    lat_hi = 3;
    clear_corrupt();
    @(negedge clk);
    run("post_rst", 4'b0001, 0, 0, 256);
    chk("post_rst_leds_80", 32'(leds), 32'h80);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
